// File: rtl/uart_word_tx.sv
// 16-bit word transmitter: sends the word as two back-to-back 8N1 frames,
// low byte first, with bit timing derived from clk by an internal baud counter.
module uart_word_tx #(
  parameter int CLK_DIV   = 5208,
  parameter int STOP_BITS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] word,
  input  logic        send,
  output logic        busy,
  output logic        done,
  output logic        tx
);

  localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic          stop_q, stop_d;
  logic          byte_q, byte_d;
  logic [15:0]   shadow_q, shadow_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          baud_end;
  logic          stop_last;
  logic [3:0]    next_idx;

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    stop_d    = stop_q;
    byte_d    = byte_q;
    shadow_d  = shadow_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    baud_end  = (baud_q == BAUD_MAX);
    stop_last = (STOP_BITS == 1) || stop_q;
    next_idx  = {byte_q, bit_q + 3'd1};

    if (state_q != IDLE) begin
      baud_d = baud_end ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = 3'd0;
        stop_d = 1'b0;
        byte_d = 1'b0;
        tx_d   = 1'b1;
        if (send) begin
          shadow_d = word;
          busy_d   = 1'b1;
          tx_d     = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        if (baud_end) begin
          state_d = DATA;
          bit_d   = 3'd0;
          tx_d    = shadow_q[{byte_q, 3'd0}];
        end
      end
      DATA: begin
        if (baud_end) begin
          if (bit_q == 3'd7) begin
            state_d = STOP;
            stop_d  = 1'b0;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shadow_q[next_idx];
          end
        end
      end
      STOP: begin
        if (baud_end) begin
          if (!stop_last) begin
            stop_d = 1'b1;
          end else if (!byte_q) begin
            // high byte follows immediately, no idle gap between frames
            byte_d  = 1'b1;
            stop_d  = 1'b0;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            stop_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= 3'd0;
      stop_q   <= 1'b0;
      byte_q   <= 1'b0;
      shadow_q <= 16'h0000;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      byte_q   <= byte_d;
      shadow_q <= shadow_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: two instances (CLK_DIV=4/STOP_BITS=1 and CLK_DIV=3/STOP_BITS=2),
// cycle-exact line checks plus a word scoreboard fed at send time and drained on done.
module tb_uart_word_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] word_a, word_b;
  logic        send_a, send_b;
  logic        busy_a, done_a, tx_a;
  logic        busy_b, done_b, tx_b;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  uart_word_tx #(.CLK_DIV(4), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .word(word_a), .send(send_a),
    .busy(busy_a), .done(done_a), .tx(tx_a)
  );

  uart_word_tx #(.CLK_DIV(3), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .word(word_b), .send(send_b),
    .busy(busy_b), .done(done_b), .tx(tx_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input bit sel, input logic s, input logic [15:0] w);
    if (sel) begin
      send_b = s;
      word_b = w;
    end else begin
      send_a = s;
      word_a = w;
    end
  endtask

  // called on a negedge; returns on the negedge right after the accepting edge
  task automatic send_word(input bit sel, input logic [15:0] w);
    drive(sel, 1'b1, w);
    exp_q.push_back(w);
    @(negedge clk);
    drive(sel, 1'b0, w);
  endtask

  task automatic idle_chk(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_tx_a", tx_a, 1);
      chk("idle_busy_a", busy_a, 0);
      chk("idle_done_a", done_a, 0);
      chk("idle_tx_b", tx_b, 1);
      chk("idle_busy_b", busy_b, 0);
      chk("idle_done_b", done_b, 0);
    end
  endtask

  // k=0 is the negedge after acceptance edge N; ends on the done cycle (or after a reset)
  task automatic watch(input bit sel, input int k_inj, input int k_rst);
    int cdiv, sb, flen, tot, f, r, b, ph;
    logic [15:0] exp_w, got_w, byte_w;
    logic exp_tx, o_tx, o_busy, o_done;
    cdiv = sel ? 3 : 4;
    sb   = sel ? 2 : 1;
    flen = (9 + sb) * cdiv;
    tot  = 2 * flen;
    got_w = 16'h0000;
    chk("sb_size", exp_q.size(), 1);
    if (exp_q.size() == 0) return;
    exp_w = exp_q.pop_front();
    for (int k = 0; k <= tot; k++) begin
      if (k > 0) @(negedge clk);
      o_tx   = sel ? tx_b : tx_a;
      o_busy = sel ? busy_b : busy_a;
      o_done = sel ? done_b : done_a;
      if (k_rst >= 0 && k == k_rst + 1) begin
        chk("rst_tx", o_tx, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        rst = 1'b0;
        return;
      end
      if (k < tot) begin
        f  = k / flen;
        r  = k % flen;
        b  = r / cdiv;
        ph = r % cdiv;
        byte_w = (f == 1) ? {8'h00, exp_w[15:8]} : {8'h00, exp_w[7:0]};
        if (b == 0)       exp_tx = 1'b0;
        else if (b <= 8)  exp_tx = byte_w[b-1];
        else              exp_tx = 1'b1;
        chk("tx_bit", o_tx, exp_tx);
        chk("busy_hi", o_busy, 1);
        chk("done_lo", o_done, 0);
        if (b >= 1 && b <= 8 && ph == cdiv / 2) got_w[f*8 + b - 1] = o_tx;
      end else begin
        chk("busy_end", o_busy, 0);
        chk("done_end", o_done, 1);
        chk("tx_end", o_tx, 1);
        chk("rx_word", got_w, exp_w);
      end
      if (k == k_inj)     drive(sel, 1'b1, 16'hFFFF);
      if (k == k_inj + 1) drive(sel, 1'b0, 16'hFFFF);
      if (k == k_rst)     rst = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 16'h0000);
    drive(1, 1'b0, 16'h0000);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle_chk(100);

    send_word(0, 16'hA53C);
    watch(0, -1, -1);
    idle_chk(5);

    send_word(0, 16'h1234);
    watch(0, 20, -1);
    idle_chk(10);

    send_word(0, 16'hABCD);
    watch(0, -1, -1);
    send_word(0, 16'h00FF);
    watch(0, -1, -1);
    idle_chk(5);

    send_word(0, 16'hC3C3);
    watch(0, -1, 60);
    idle_chk(10);
    send_word(0, 16'h5A5A);
    watch(0, -1, -1);
    idle_chk(5);

    rst = 1'b1;
    drive(0, 1'b1, 16'h1111);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1'b0, 16'h1111);
    idle_chk(20);

    send_word(1, 16'h0001);
    watch(1, -1, -1);
    idle_chk(5);

    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
